// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the systolic-array edge feeder.
//   SA_N, SA_DW, SA_PIPE_LAT : default array size, element width and PE multiply latency
//   state_t                  : edge-feeder run state
//   drain_len()              : cycles needed to flush the PE pipeline after the last A skew
package sa_pkg;

  localparam int SA_N        = 4;
  localparam int SA_DW       = 16;
  localparam int SA_PIPE_LAT = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    BLOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Last A element enters at the far column, passes the multiplier pipeline,
  // then walks down N rows of partial-sum registers.
  function automatic int drain_len(input int n, input int pipe_lat);
    return pipe_lat + n + 1;
  endfunction

endpackage

// File: rtl/sa_tile_bank.sv
// sa_tile_bank: N x N register bank holding one operand tile.
//   Clock, rst_n    : clock, asynchronous active-low reset (clears the tile)
//   wr_en, wr_row   : row write strobe and row index
//   wr_data         : row data, element j at bits [j*DW +: DW]
//   rd_row, rd_col  : N independent read addresses, port p at bits [p*IW +: IW]
//   rd_data         : N combinational read results, port p at bits [p*DW +: DW]
module sa_tile_bank
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW
) (
  input  logic                      Clock,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(N)-1:0]      wr_row,
  input  logic [N*DW-1:0]           wr_data,
  input  logic [N*$clog2(N)-1:0]    rd_row,
  input  logic [N*$clog2(N)-1:0]    rd_col,
  output logic [N*DW-1:0]           rd_data
);

  localparam int IW = $clog2(N);

  logic [N-1:0][DW-1:0] mem [N];

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      rd_data[p*DW +: DW] = mem[rd_row[p*IW +: IW]][rd_col[p*IW +: IW]];
    end
  end

endmodule

// File: rtl/sa_edge_feeder.sv
// sa_edge_feeder: top/left edge driver of an N x N weight-stationary PE grid.
//   Clock, rst_n        : clock, asynchronous active-low reset
//   ld_valid/ld_ready   : tile-row write handshake (ready only while idle)
//   ld_is_b, ld_row     : target bank (0 = A, 1 = B) and row index
//   ld_data             : row data, element j at bits [j*DW +: DW]
//   start               : begin a run (honoured only while idle)
//   busy, done          : run in progress / one-cycle end-of-run pulse
//   data_clear, en_*    : PE control broadcasts
//   b_top_out           : B preload into top-row PEs, column c at [c*DW +: DW]
//   a_left_out          : skewed A into left-column PEs, row r at [r*DW +: DW]
// All outputs are decoded from registered state, counter and bank contents.
module sa_edge_feeder
  import sa_pkg::*;
#(
  parameter int N        = SA_N,
  parameter int DW       = SA_DW,
  parameter int PIPE_LAT = SA_PIPE_LAT
) (
  input  logic                 Clock,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 ld_is_b,
  input  logic [$clog2(N)-1:0] ld_row,
  input  logic [N*DW-1:0]      ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 data_clear,
  output logic                 en_b_shift_bottom,
  output logic                 en_shift_right,
  output logic                 en_shift_bottom,
  output logic [N*DW-1:0]      b_top_out,
  output logic [N*DW-1:0]      a_left_out
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(PIPE_LAT + 2*N + 2);

  localparam logic [CW-1:0] B_LAST = CW'(N - 1);
  localparam logic [CW-1:0] S_LAST = CW'(2*N - 2);
  localparam logic [CW-1:0] D_LAST = CW'(drain_len(N, PIPE_LAT) - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic            wr_a, wr_b;
  logic [N*IW-1:0] a_rd_row, a_rd_col, b_rd_row, b_rd_col;
  logic [N*DW-1:0] a_rd_data, b_rd_data;
  logic [N-1:0]    a_ok;
  int              d;

  assign wr_a = ld_valid && (state == IDLE) && !ld_is_b;
  assign wr_b = ld_valid && (state == IDLE) &&  ld_is_b;

  sa_tile_bank #(.N(N), .DW(DW)) u_bank_a (
    .Clock   (Clock),
    .rst_n   (rst_n),
    .wr_en   (wr_a),
    .wr_row  (ld_row),
    .wr_data (ld_data),
    .rd_row  (a_rd_row),
    .rd_col  (a_rd_col),
    .rd_data (a_rd_data)
  );

  sa_tile_bank #(.N(N), .DW(DW)) u_bank_b (
    .Clock   (Clock),
    .rst_n   (rst_n),
    .wr_en   (wr_b),
    .wr_row  (ld_row),
    .wr_data (ld_data),
    .rd_row  (b_rd_row),
    .rd_col  (b_rd_col),
    .rd_data (b_rd_data)
  );

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter restarts on every state entry; each state leaves on its terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = BLOAD;
      end
      BLOAD: if (cnt == B_LAST) begin
        cnt_nxt   = '0;
        state_nxt = STREAM;
      end
      STREAM: if (cnt == S_LAST) begin
        cnt_nxt   = '0;
        state_nxt = DRAIN;
      end
      DRAIN: if (cnt == D_LAST) begin
        cnt_nxt   = '0;
        state_nxt = DONE;
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // B is pushed bottom row first so that after N shifts PE(r,c) holds B[r][c].
  // Left-column row r sees A[k-r][r]: one cycle of skew per row.
  always_comb begin
    a_rd_row = '0;
    a_rd_col = '0;
    b_rd_row = '0;
    b_rd_col = '0;
    a_ok     = '0;
    d        = 0;
    for (int p = 0; p < N; p++) begin
      d = int'(cnt) - p;
      a_ok[p]              = (d >= 0) && (d < N);
      a_rd_row[p*IW +: IW] = IW'(d);
      a_rd_col[p*IW +: IW] = IW'(p);
      b_rd_row[p*IW +: IW] = IW'(N - 1 - int'(cnt));
      b_rd_col[p*IW +: IW] = IW'(p);
    end
  end

  always_comb begin
    ld_ready          = (state == IDLE);
    busy              = (state != IDLE);
    done              = 1'b0;
    data_clear        = 1'b0;
    en_b_shift_bottom = 1'b0;
    en_shift_right    = 1'b0;
    en_shift_bottom   = 1'b0;
    b_top_out         = '0;
    a_left_out        = '0;
    case (state)
      CLEAR: data_clear = 1'b1;
      BLOAD: begin
        en_b_shift_bottom = 1'b1;
        b_top_out         = b_rd_data;
      end
      STREAM: begin
        en_shift_right  = 1'b1;
        en_shift_bottom = 1'b1;
        for (int p = 0; p < N; p++) begin
          if (a_ok[p]) a_left_out[p*DW +: DW] = a_rd_data[p*DW +: DW];
        end
      end
      DRAIN: begin
        en_shift_right  = 1'b1;
        en_shift_bottom = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sa_edge_feeder.sv
// tb_sa_edge_feeder: directed bench for sa_edge_feeder driving a behavioural
// 4x4 weight-stationary PE grid. Trace index e = cycle following the e-th
// rising edge, counting the edge that samples start as edge 0.
module tb_sa_edge_feeder;

  localparam int N        = 4;
  localparam int DW       = 16;
  localparam int PIPE_LAT = 6;
  localparam int RUN      = 26;

  logic          Clock = 1'b0;
  logic          rst_n, ld_valid, ld_is_b, start;
  logic [1:0]    ld_row;
  logic [N*DW-1:0] ld_data;
  logic          ld_ready, busy, done, data_clear;
  logic          en_b_shift_bottom, en_shift_right, en_shift_bottom;
  logic [N*DW-1:0] b_top_out, a_left_out;

  sa_edge_feeder #(.N(N), .DW(DW), .PIPE_LAT(PIPE_LAT)) dut (
    .Clock             (Clock),
    .rst_n             (rst_n),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_is_b           (ld_is_b),
    .ld_row            (ld_row),
    .ld_data           (ld_data),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .data_clear        (data_clear),
    .en_b_shift_bottom (en_b_shift_bottom),
    .en_shift_right    (en_shift_right),
    .en_shift_bottom   (en_shift_bottom),
    .b_top_out         (b_top_out),
    .a_left_out        (a_left_out)
  );

  always #5 Clock = ~Clock;

  // Behavioural PE grid: B stationary, A shifts right, products pass a
  // PIPE_LAT-deep pipeline, partial sums shift down one row per cycle.
  logic [DW-1:0] m_a [N][N];
  logic [DW-1:0] m_b [N][N];
  logic [DW-1:0] m_ps[N][N];
  logic [DW-1:0] m_p [N][N][PIPE_LAT];

  always_ff @(posedge Clock) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (data_clear) begin
          m_a[r][c]  <= '0;
          m_ps[r][c] <= '0;
          for (int s = 0; s < PIPE_LAT; s++) m_p[r][c][s] <= '0;
        end else begin
          if (en_b_shift_bottom) begin
            if (r == 0) m_b[r][c] <= b_top_out[c*DW +: DW];
            else        m_b[r][c] <= m_b[r-1][c];
          end
          if (en_shift_right) begin
            if (c == 0) m_a[r][c] <= a_left_out[r*DW +: DW];
            else        m_a[r][c] <= m_a[r][c-1];
            m_p[r][c][0] <= DW'(m_a[r][c] * m_b[r][c]);
            for (int s = 1; s < PIPE_LAT; s++) m_p[r][c][s] <= m_p[r][c][s-1];
          end
          if (en_shift_bottom) begin
            if (r == 0) m_ps[r][c] <= m_p[r][c][PIPE_LAT-1];
            else        m_ps[r][c] <= m_ps[r-1][c] + m_p[r][c][PIPE_LAT-1];
          end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ea[N][N], eb[N][N], ec[N][N];

  logic          tr_clear[RUN], tr_bsh[RUN], tr_sr[RUN], tr_sb[RUN];
  logic          tr_done[RUN], tr_busy[RUN], tr_rdy[RUN];
  logic [N*DW-1:0] tr_b[RUN], tr_a[RUN];
  logic [DW-1:0] tr_ps[RUN][N];

  function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [N*DW-1:0] arow(input int i);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = ea[i][j];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] brow(input int i);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = eb[i][j];
    return v;
  endfunction

  function automatic int first_done();
    for (int e = 0; e < RUN; e++) if (tr_done[e] === 1'b1) return e;
    return -1;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_row(input logic is_b, input int row, input logic [N*DW-1:0] data);
    ld_valid = 1'b1;
    ld_is_b  = is_b;
    ld_row   = 2'(row);
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_mats();
    for (int i = 0; i < N; i++) begin
      load_row(1'b0, i, arow(i));
      load_row(1'b1, i, brow(i));
    end
  endtask

  task automatic compute_c();
    logic [DW-1:0] s;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int r = 0; r < N; r++) s = s + DW'(ea[i][r] * eb[r][c]);
        ec[i][c] = s;
      end
    end
  endtask

  // One run: start (optionally with an A row-0 write), trace RUN cycles.
  // inj_e: cycle in which start and a junk A row-0 write are attempted.
  // rst_e: cycle in which rst_n is pulsed low.
  task automatic do_run(input int inj_e, input int rst_e, input logic sl_en,
                        input logic [N*DW-1:0] sl_data);
    start    = 1'b1;
    ld_valid = sl_en;
    ld_is_b  = 1'b0;
    ld_row   = 2'd0;
    ld_data  = sl_data;
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    for (int e = 0; e < RUN; e++) begin
      if (e == rst_e) begin
        rst_n = 1'b0;
        #1;
      end
      tr_clear[e] = data_clear;
      tr_bsh[e]   = en_b_shift_bottom;
      tr_sr[e]    = en_shift_right;
      tr_sb[e]    = en_shift_bottom;
      tr_done[e]  = done;
      tr_busy[e]  = busy;
      tr_rdy[e]   = ld_ready;
      tr_b[e]     = b_top_out;
      tr_a[e]     = a_left_out;
      for (int c = 0; c < N; c++) tr_ps[e][c] = m_ps[N-1][c];
      if (e == rst_e) rst_n = 1'b1;
      if (e == inj_e) begin
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_is_b  = 1'b0;
        ld_row   = 2'd0;
        ld_data  = {N{16'hDEAD}};
      end
      tick();
      start    = 1'b0;
      ld_valid = 1'b0;
    end
  endtask

  task automatic set_skew_a_seq_b();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ea[i][j] = DW'(16*i + j);
        eb[i][j] = DW'(4*i + j + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready=%b busy=%b done=%b expected 1 0 0", ld_ready, busy, done);
    end
    checks++;
    if ({data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_enables: got %b expected 0000",
               {data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom});
    end
    checks++;
    if (b_top_out !== '0 || a_left_out !== '0) begin
      errors++;
      $display("FAIL reset_data: b=%h a=%h expected 0", b_top_out, a_left_out);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bload();
    int n_clr, n_bsh;
    set_skew_a_seq_b();
    load_mats();
    do_run(-1, -1, 1'b0, '0);
    n_clr = 0;
    n_bsh = 0;
    for (int e = 0; e < RUN; e++) begin
      if (tr_clear[e] === 1'b1) n_clr++;
      if (tr_bsh[e] === 1'b1) n_bsh++;
    end
    checks++;
    if (tr_clear[0] !== 1'b1 || n_clr != 1) begin
      errors++;
      $display("FAIL bload_clear: first=%b count=%0d expected 1 and 1", tr_clear[0], n_clr);
    end
    checks++;
    if (n_bsh != 4 || {tr_bsh[1], tr_bsh[2], tr_bsh[3], tr_bsh[4]} !== 4'b1111) begin
      errors++;
      $display("FAIL bload_enable: count=%0d expected 4 in cycles 1..4", n_bsh);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (tr_b[1+k] !== brow(N-1-k)) begin
        errors++;
        $display("FAIL bload_row k=%0d: got %h expected %h", k, tr_b[1+k], brow(N-1-k));
      end
    end
    checks++;
    if (tr_b[5] !== '0) begin
      errors++;
      $display("FAIL bload_stream_zero: got %h expected 0", tr_b[5]);
    end
  endtask

  task automatic test_skew();
    set_skew_a_seq_b();
    load_mats();
    do_run(-1, -1, 1'b0, '0);
    checks++;
    if (tr_a[5] !== pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000)) begin
      errors++;
      $display("FAIL skew_k0: got %h expected 0", tr_a[5]);
    end
    checks++;
    if (tr_a[8] !== pack4(16'h0030, 16'h0021, 16'h0012, 16'h0003)) begin
      errors++;
      $display("FAIL skew_k3: got %h expected %h", tr_a[8], pack4(16'h0030, 16'h0021, 16'h0012, 16'h0003));
    end
    checks++;
    if (tr_a[11] !== pack4(16'h0000, 16'h0000, 16'h0000, 16'h0033)) begin
      errors++;
      $display("FAIL skew_k6: got %h expected %h", tr_a[11], pack4(16'h0000, 16'h0000, 16'h0000, 16'h0033));
    end
    checks++;
    if (tr_a[12] !== '0 || tr_sr[12] !== 1'b1 || tr_sb[22] !== 1'b1 || tr_sr[23] !== 1'b0) begin
      errors++;
      $display("FAIL skew_drain: a=%h sr12=%b sb22=%b sr23=%b expected 0 1 1 0",
               tr_a[12], tr_sr[12], tr_sb[22], tr_sr[23]);
    end
  endtask

  // C[i][c] leaves the bottom of column c in trace cycle 16+i+c.
  task automatic check_c(input string tag);
    compute_c();
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < N; c++) begin
        checks++;
        if (tr_ps[16+i+c][c] !== ec[i][c]) begin
          errors++;
          $display("FAIL %s C[%0d][%0d]: got %h expected %h", tag, i, c, tr_ps[16+i+c][c], ec[i][c]);
        end
      end
    end
  endtask

  task automatic test_end_to_end();
    set_skew_a_seq_b();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ea[i][j] = (i == j) ? 16'd1 : 16'd0;
    load_mats();
    do_run(-1, -1, 1'b0, '0);
    check_c("e2e");
    checks++;
    if (first_done() != 23 || tr_done[22] !== 1'b0 || tr_done[24] !== 1'b0) begin
      errors++;
      $display("FAIL e2e_done_time: first done cycle %0d expected 23 (single pulse)", first_done());
    end
    checks++;
    if (tr_busy[22] !== 1'b1 || tr_busy[24] !== 1'b0 || tr_rdy[24] !== 1'b1) begin
      errors++;
      $display("FAIL e2e_busy: busy22=%b busy24=%b rdy24=%b expected 1 0 1",
               tr_busy[22], tr_busy[24], tr_rdy[24]);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = 16'h0100;
        eb[i][j] = 16'h0100;
      end
    load_mats();
    do_run(-1, -1, 1'b0, '0);
    check_c("wrap");
  endtask

  task automatic test_handshake();
    set_skew_a_seq_b();
    load_mats();
    do_run(8, -1, 1'b0, '0);
    checks++;
    if (tr_rdy[8] !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: got %b expected 0", tr_rdy[8]);
    end
    checks++;
    if (first_done() != 23 || tr_busy[24] !== 1'b0 || tr_busy[25] !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: done cycle %0d busy24=%b busy25=%b expected 23 0 0",
               first_done(), tr_busy[24], tr_busy[25]);
    end
    do_run(-1, -1, 1'b0, '0);
    checks++;
    if (tr_a[8] !== pack4(16'h0030, 16'h0021, 16'h0012, 16'h0003)) begin
      errors++;
      $display("FAIL busy_no_write: got %h expected %h", tr_a[8], pack4(16'h0030, 16'h0021, 16'h0012, 16'h0003));
    end
    do_run(-1, -1, 1'b1, pack4(16'h0ABC, 16'h0ABD, 16'h0ABE, 16'h0ABF));
    checks++;
    if (tr_a[5] !== pack4(16'h0ABC, 16'h0000, 16'h0000, 16'h0000)) begin
      errors++;
      $display("FAIL same_cycle_k0: got %h expected %h", tr_a[5], pack4(16'h0ABC, 16'h0000, 16'h0000, 16'h0000));
    end
    checks++;
    if (tr_a[8] !== pack4(16'h0030, 16'h0021, 16'h0012, 16'h0ABF)) begin
      errors++;
      $display("FAIL same_cycle_k3: got %h expected %h", tr_a[8], pack4(16'h0030, 16'h0021, 16'h0012, 16'h0ABF));
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    logic [N*DW-1:0] acc_b, acc_a;
    set_skew_a_seq_b();
    load_mats();
    do_run(-1, 8, 1'b0, '0);
    checks++;
    if (tr_rdy[8] !== 1'b1 || tr_busy[8] !== 1'b0 ||
        {tr_clear[8], tr_bsh[8], tr_sr[8], tr_sb[8]} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_ctrl: rdy=%b busy=%b en=%b expected 1 0 0000", tr_rdy[8], tr_busy[8],
               {tr_clear[8], tr_bsh[8], tr_sr[8], tr_sb[8]});
    end
    checks++;
    if (tr_a[8] !== '0 || tr_b[8] !== '0) begin
      errors++;
      $display("FAIL rstmid_data: a=%h b=%h expected 0", tr_a[8], tr_b[8]);
    end
    n_done = 0;
    for (int e = 0; e < RUN; e++) if (tr_done[e] !== 1'b0) n_done++;
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d done cycles expected 0", n_done);
    end
    do_run(-1, -1, 1'b0, '0);
    acc_b = '0;
    acc_a = '0;
    for (int e = 1; e <= 4; e++) acc_b = acc_b | tr_b[e];
    for (int e = 5; e <= 11; e++) acc_a = acc_a | tr_a[e];
    checks++;
    if (acc_b !== '0 || tr_bsh[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_b_zero: or of b_top_out %h expected 0", acc_b);
    end
    checks++;
    if (acc_a !== '0 || tr_sr[5] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_a_zero: or of a_left_out %h expected 0", acc_a);
    end
  endtask

  initial begin
    ld_valid = 1'b0;
    ld_is_b  = 1'b0;
    ld_row   = 2'd0;
    ld_data  = '0;
    start    = 1'b0;
    test_reset();
    test_bload();
    test_skew();
    test_end_to_end();
    test_wrap();
    test_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
